// File: rtl/kiwi_waypoint_reporter.sv
// kiwi_waypoint_reporter
//   Assembles a byte-serial ASCII stream into packed waypoint strings and
//   owns the sticky abend syndrome register polled by the sim wrapper.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   wp_char_valid/ready - character handshake (ready only while collecting)
//   wp_char, wp_char_last
//                       - character and end-of-waypoint marker
//   abend_valid, abend_code
//                       - request to record an exit/abend code
//   KppWaypoint0/1      - newest / previous published waypoint, last char in [7:0]
//   hpr_abend_syndrome  - RUNNING_CODE until an abend is recorded
//   wp_count            - number of waypoints published (wraps)
//   wp_truncated        - KppWaypoint0 lost characters to overflow
module kiwi_waypoint_reporter #(
    parameter int          WP_CHARS     = 80,
    parameter logic [7:0]  RUNNING_CODE = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wp_char_valid,
    output logic                    wp_char_ready,
    input  logic [7:0]              wp_char,
    input  logic                    wp_char_last,
    input  logic                    abend_valid,
    input  logic [7:0]              abend_code,
    output logic [8*WP_CHARS-1:0]   KppWaypoint0,
    output logic [8*WP_CHARS-1:0]   KppWaypoint1,
    output logic [7:0]              hpr_abend_syndrome,
    output logic [15:0]             wp_count,
    output logic                    wp_truncated
);

    localparam int W  = 8 * WP_CHARS;
    localparam int LW = $clog2(WP_CHARS + 1);

    typedef enum logic [1:0] {
        PUBLISH = 2'd0,
        COLLECT = 2'd1,
        FROZEN  = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    assy;
    logic [LW-1:0]   len;
    logic            trunc_flag;

    logic            hs;
    logic            abend_hit;
    logic            publish;
    logic [W-1:0]    assy_n;
    logic [LW-1:0]   len_n;
    logic            trunc_n;

    // Ready is a pure decode of registered state: no input-to-output path.
    assign wp_char_ready = (state == COLLECT);

    always_comb begin
        hs        = wp_char_valid && (state == COLLECT);
        abend_hit = abend_valid && (hpr_abend_syndrome == RUNNING_CODE)
                    && (abend_code != RUNNING_CODE);
        assy_n    = assy;
        len_n     = len;
        trunc_n   = trunc_flag;
        // NUL is consumed as padding: accepted but never stored or counted.
        if (hs && (wp_char != 8'h00)) begin
            if (len < LW'(WP_CHARS)) begin
                assy_n = {assy[W-9:0], wp_char};
                len_n  = len + 1'b1;
            end else begin
                trunc_n = 1'b1;
            end
        end
        // The last character is folded in first, so a one-char message publishes.
        publish = hs && wp_char_last && (len_n != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= PUBLISH;
            assy               <= '0;
            len                <= '0;
            trunc_flag         <= 1'b0;
            KppWaypoint0       <= '0;
            KppWaypoint1       <= '0;
            hpr_abend_syndrome <= RUNNING_CODE;
            wp_count           <= '0;
            wp_truncated       <= 1'b0;
        end else begin
            if (publish) begin
                KppWaypoint1 <= KppWaypoint0;
                KppWaypoint0 <= assy_n;
                wp_truncated <= trunc_n;
                wp_count     <= wp_count + 16'd1;
            end

            // Any end-of-message or an abend drops whatever is being assembled.
            if (abend_hit || (hs && wp_char_last)) begin
                assy       <= '0;
                len        <= '0;
                trunc_flag <= 1'b0;
            end else begin
                assy       <= assy_n;
                len        <= len_n;
                trunc_flag <= trunc_n;
            end

            if (abend_hit)
                hpr_abend_syndrome <= abend_code;

            case (state)
                PUBLISH: state <= abend_hit ? FROZEN : COLLECT;
                COLLECT: begin
                    if (abend_hit)
                        state <= FROZEN;
                    else if (publish)
                        state <= PUBLISH;
                end
                FROZEN:  state <= FROZEN;
                default: state <= PUBLISH;
            endcase
        end
    end

endmodule

// File: doc/kiwi_waypoint_reporter.md
# kiwi_waypoint_reporter

DUT-side source of the Kiwi waypoint/abend reporting interface. It accepts a byte-serial ASCII stream from the generated control FSM and assembles each message into an 80-character packed string. Each completed string is published on `KppWaypoint0`, and the previous one is retained on `KppWaypoint1`. It also owns the sticky `hpr_abend_syndrome` register that the simulation wrapper polls to decide when a run has finished.

## Interface
- `WP_CHARS`, default 80: string capacity in characters; string width is 8*WP_CHARS.
- `RUNNING_CODE`, default 8'hFF: syndrome value meaning "still running".
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; the block is held reset while low.
- `wp_char_valid` in 1: a character is offered.
- `wp_char_ready` out 1: the block accepts the offered character this cycle.
- `wp_char` in 8: ASCII character.
- `wp_char_last` in 1: this character ends the current waypoint.
- `abend_valid` in 1: request to record an abend/exit code.
- `abend_code` in 8: the code to record.
- `KppWaypoint0` out 8*WP_CHARS: most recent waypoint, last character in bits [7:0].
- `KppWaypoint1` out 8*WP_CHARS: the waypoint published before `KppWaypoint0`.
- `hpr_abend_syndrome` out 8: RUNNING_CODE until an abend is recorded, then the recorded code.
- `wp_count` out 16: number of waypoints published.
- `wp_truncated` out 1: the waypoint on `KppWaypoint0` lost characters to overflow.

## Operation
- States: PUBLISH, COLLECT, FROZEN.
  - `wp_char_ready` = (state == COLLECT).
  - Handshake = `wp_char_valid` & `wp_char_ready`.
- Reset values:
  - state = PUBLISH, so ready = 0.
  - `KppWaypoint0` = `KppWaypoint1` = 0.
  - `hpr_abend_syndrome` = RUNNING_CODE.
  - `wp_count` = 0, `wp_truncated` = 0.
  - Assembly register = 0, length = 0, trunc flag = 0.
- PUBLISH → COLLECT unconditionally on the next edge, unless an abend has been recorded, in which case → FROZEN.
- COLLECT, on each handshake:
  - `wp_char` == 8'h00: accepted, but not stored and not counted.
  - Otherwise, if length < WP_CHARS: assy <= {assy[8*WP_CHARS-9:0], wp_char}, length++.
  - Otherwise the character is dropped and the trunc flag is set.
- Handshake with `wp_char_last` = 1 (the final character is applied first under the rules above). If the resulting length > 0:
  - `KppWaypoint1` <= `KppWaypoint0`.
  - `KppWaypoint0` <= assy.
  - `wp_truncated` <= trunc flag.
  - `wp_count` <= `wp_count` + 1, wrapping 65535 → 0.
  - Clear assy, length and trunc flag.
  - → PUBLISH.
- Handshake with `wp_char_last` = 1 and length 0 (empty or all-NUL message): nothing is published or counted, assy is cleared, and the state stays COLLECT.
- Republishing a string identical to the current `KppWaypoint0` is still published and counted.
- Abend:
  - `abend_valid` while syndrome == RUNNING_CODE and `abend_code` != RUNNING_CODE: syndrome <= `abend_code`.
  - The syndrome is sticky until reset; later abends are ignored.
  - On recording, the partial assembly is discarded and the state goes → FROZEN.
  - `abend_valid` with `abend_code` == RUNNING_CODE is ignored.
- FROZEN: ready = 0 and all outputs hold until reset.
- Abend and a last-character handshake in the same cycle: the waypoint is published *and* the abend recorded, both on that edge; next state FROZEN.
- Reset asserted mid-message: all state returns to its reset values immediately, and the partial string is lost.

## Timing
- Character accepted at edge N with last: `KppWaypoint0`, `KppWaypoint1`, `wp_count` and `wp_truncated` change at edge N, visible after N.
- `wp_char_ready` is low for exactly one cycle after each publish.
- A k-character waypoint (k ≥ 1) therefore occupies k+1 cycles at full rate.
- Abend recorded at edge N: `hpr_abend_syndrome` is valid after N, and ready is low from N.
- After `reset` deasserts, ready rises after the first rising edge of `clk`.
- No combinational path from any input to any output.

## Test plan
- Reset, release, then stream "Start" (5 chars, last on 't') at full rate → `KppWaypoint0` = 40'h5374617274 zero-extended, `KppWaypoint1` = 0, `wp_count` = 1, ready low for one cycle after 't'.
- Send "A" then "BC" → `KppWaypoint0` = 16'h4243, `KppWaypoint1` = 8'h41, `wp_count` = 2. Insert `wp_char_valid` bubbles between characters → same result.
- Send 85 chars 'a'..'e' repeating, last on the 85th → `KppWaypoint0` holds the first 80 chars, `wp_truncated` = 1. The next 2-char waypoint → `wp_truncated` = 0.
- Send NUL, NUL (last) → no change, `wp_count` unchanged, ready stays high. Send "X" framed by NULs → `KppWaypoint0` = 8'h58.
- `abend_valid` with code 8'h00 mid-message "Hel" → syndrome = 8'h00 next cycle, ready stays 0, `KppWaypoint0` unchanged. A later `abend_valid` with code 8'h05 → syndrome remains 8'h00.
- Abend 8'h03 coincident with the last char of "Z" → `KppWaypoint0` = 8'h5A and syndrome = 8'h03 on the same edge. Assert `reset` low asynchronously mid-cycle → all outputs return to reset values without waiting for a clock edge.
